// File: rtl/avg_downscale_ctrl.sv
// 2x2 block-average downscale sequencer: four source reads per output pixel,
// accumulate the returned pixels, then write sum>>2 to the destination with a ready handshake.
module avg_downscale_ctrl #(
  parameter int SRC_W  = 320,
  parameter int SRC_H  = 240,
  parameter int RD_LAT = 2,
  parameter int ADDR_W = 17,
  parameter int PIX_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              src_rd,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [PIX_W-1:0]  src_data,
  output logic              dst_we,
  input  logic              dst_ready,
  output logic [ADDR_W-1:0] dst_addr,
  output logic [PIX_W-1:0]  dst_data
);
  localparam int DST_W = SRC_W / 2;
  localparam int DST_H = SRC_H / 2;
  localparam int OX_W  = $clog2(DST_W + 1);
  localparam int OY_W  = $clog2(DST_H + 1);
  localparam int SUM_W = PIX_W + 2;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  logic [2:0]        r_state;
  logic [1:0]        r_k;
  logic [2:0]        r_drain;
  logic [OX_W-1:0]   r_ox;
  logic [OY_W-1:0]   r_oy;
  logic [ADDR_W-1:0] r_row_base;
  logic [ADDR_W-1:0] r_dst_cnt;
  logic [ADDR_W-1:0] r_src_addr_hold;
  logic [SUM_W-1:0]  r_sum;
  logic [PIX_W-1:0]  r_dst_data_hold;
  logic [RD_LAT-1:0] r_vpipe;

  logic              w_issue;
  logic              w_write;
  logic              w_ox_last;
  logic              w_oy_last;
  logic [RD_LAT:0]   w_vpipe_next;
  logic [ADDR_W-1:0] w_rd_addr;

  assign w_issue   = (r_state == S_ISSUE);
  assign w_write   = (r_state == S_WRITE);
  assign w_ox_last = (r_ox == OX_W'(DST_W - 1));
  assign w_oy_last = (r_oy == OY_W'(DST_H - 1));

  // Top bit is src_rd delayed by exactly RD_LAT cycles: the accumulate enable.
  assign w_vpipe_next = {r_vpipe, w_issue};

  // k[0] picks the right column of the block, k[1] the lower row.
  assign w_rd_addr = r_row_base + ADDR_W'({r_ox, 1'b0}) + ADDR_W'(r_k[0])
                   + (r_k[1] ? ADDR_W'(SRC_W) : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_k             <= '0;
      r_drain         <= '0;
      r_ox            <= '0;
      r_oy            <= '0;
      r_row_base      <= '0;
      r_dst_cnt       <= '0;
      r_src_addr_hold <= '0;
      r_sum           <= '0;
      r_dst_data_hold <= '0;
      r_vpipe         <= '0;
    end else begin
      r_vpipe <= w_vpipe_next[RD_LAT-1:0];
      if (w_vpipe_next[RD_LAT]) begin
        r_sum <= r_sum + SUM_W'(src_data);
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_ISSUE;
            r_k        <= '0;
            r_ox       <= '0;
            r_oy       <= '0;
            r_row_base <= '0;
            r_dst_cnt  <= '0;
            r_sum      <= '0;
          end
        end
        S_ISSUE: begin
          r_src_addr_hold <= w_rd_addr;
          r_k             <= r_k + 2'd1;
          if (r_k == 2'd3) begin
            r_state <= S_DRAIN;
            r_drain <= '0;
          end
        end
        S_DRAIN: begin
          r_drain <= r_drain + 3'd1;
          if (r_drain == 3'(RD_LAT - 1)) begin
            r_state <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (dst_ready) begin
            r_dst_data_hold <= r_sum[SUM_W-1:2];
            r_sum           <= '0;
            r_dst_cnt       <= r_dst_cnt + ADDR_W'(1);
            r_k             <= '0;
            if (w_ox_last) begin
              r_ox       <= '0;
              r_oy       <= r_oy + OY_W'(1);
              r_row_base <= r_row_base + ADDR_W'(2 * SRC_W);
            end else begin
              r_ox <= r_ox + OX_W'(1);
            end
            r_state <= (w_ox_last && w_oy_last) ? S_FIN : S_ISSUE;
          end
        end
        S_FIN:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy     = (r_state == S_ISSUE) || (r_state == S_DRAIN) || w_write;
  assign done     = (r_state == S_FIN);
  assign src_rd   = w_issue;
  assign src_addr = w_issue ? w_rd_addr : r_src_addr_hold;
  assign dst_we   = w_write;
  assign dst_addr = r_dst_cnt;
  assign dst_data = w_write ? r_sum[SUM_W-1:2] : r_dst_data_hold;

endmodule

// File: tb/tb_avg_downscale_ctrl.sv
// Bench for avg_downscale_ctrl: a 4x4 instance driven through a scoreboard,
// plus a 320-wide instance for the row-wrap and final-address corner.
module tb_avg_downscale_ctrl;
  localparam int RD_LAT = 2;
  localparam int ADDR_W = 17;
  localparam int PIX_W  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, start, dst_ready;
  logic              busy, done, src_rd, dst_we;
  logic [ADDR_W-1:0] src_addr, dst_addr;
  logic [PIX_W-1:0]  src_data, dst_data;

  logic              b_start, b_ready;
  logic              b_busy, b_done, b_src_rd, b_dst_we;
  logic [ADDR_W-1:0] b_src_addr, b_dst_addr;
  logic [PIX_W-1:0]  b_src_data, b_dst_data;

  avg_downscale_ctrl #(.SRC_W(4), .SRC_H(4), .RD_LAT(RD_LAT), .ADDR_W(ADDR_W), .PIX_W(PIX_W)) u_dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .src_rd(src_rd), .src_addr(src_addr), .src_data(src_data),
    .dst_we(dst_we), .dst_ready(dst_ready), .dst_addr(dst_addr), .dst_data(dst_data)
  );

  avg_downscale_ctrl #(.SRC_W(320), .SRC_H(4), .RD_LAT(RD_LAT), .ADDR_W(ADDR_W), .PIX_W(PIX_W)) u_wide (
    .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
    .src_rd(b_src_rd), .src_addr(b_src_addr), .src_data(b_src_data),
    .dst_we(b_dst_we), .dst_ready(b_ready), .dst_addr(b_dst_addr), .dst_data(b_dst_data)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Source RAM models: data appears exactly RD_LAT cycles after the read strobe,
  // and a junk value otherwise so mistimed accumulation shows up.
  logic [7:0] mem [16];
  logic [7:0] rd_pipe [RD_LAT];
  logic [7:0] b_pipe [RD_LAT];
  always @(posedge clk) begin
    rd_pipe[0] <= src_rd ? mem[src_addr[3:0]] : 8'hA5;
    b_pipe[0]  <= b_src_rd ? b_src_addr[7:0] : 8'h5A;
    for (int i = 1; i < RD_LAT; i++) begin
      rd_pipe[i] <= rd_pipe[i-1];
      b_pipe[i]  <= b_pipe[i-1];
    end
  end
  assign src_data   = rd_pipe[RD_LAT-1];
  assign b_src_data = b_pipe[RD_LAT-1];

  // Scoreboard for the 4x4 instance.
  int exp_rd [$];
  int exp_wa [$];
  int exp_wd [$];
  int done_cnt = 0;
  logic prev_done = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (src_rd) begin
        if (exp_rd.size() == 0) chk("unexpected_src_rd_addr", src_addr, -1);
        else chk("src_addr", src_addr, exp_rd.pop_front());
      end
      if (dst_we && dst_ready) begin
        if (exp_wa.size() == 0) begin
          chk("unexpected_write_addr", dst_addr, -1);
        end else begin
          chk("dst_addr", dst_addr, exp_wa.pop_front());
          chk("dst_data", dst_data, exp_wd.pop_front());
        end
      end
      if (done) begin
        done_cnt++;
        chk("busy_in_done_cycle", busy, 0);
        chk("done_single_cycle", prev_done, 0);
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  // Wide instance: remember the last four reads and the last write.
  int b_rd_hist [4];
  int b_wr_cnt = 0;
  int b_last_wa = -1;
  int b_last_wd = -1;
  always @(negedge clk) begin
    if (!rst) begin
      if (b_src_rd) begin
        for (int i = 0; i < 3; i++) b_rd_hist[i] = b_rd_hist[i+1];
        b_rd_hist[3] = int'(b_src_addr);
      end
      if (b_dst_we) begin
        b_wr_cnt++;
        b_last_wa = int'(b_dst_addr);
        b_last_wd = int'(b_dst_data);
      end
    end
  end

  int rd_seq [16] = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};
  int base_wd [4] = '{10, 18, 42, 50};

  typedef struct packed {
    logic [7:0] p0, p1, p2, p3, avg;
  } vec_t;
  vec_t vecs [5];

  task automatic load_mem();
    for (int i = 0; i < 16; i++) mem[i] = 8'(i * 4);
  endtask

  task automatic push_pass(input int wd0);
    for (int i = 0; i < 16; i++) exp_rd.push_back(rd_seq[i]);
    for (int j = 0; j < 4; j++) begin
      exp_wa.push_back(j);
      exp_wd.push_back(j == 0 ? wd0 : base_wd[j]);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < budget);
    if (!done) chk("done_timeout", n, -1);
  endtask

  task automatic check_pass_end(input string tag, input int d0);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_done_count"}, done_cnt - d0, 1);
    chk({tag, "_reads_left"}, exp_rd.size(), 0);
    chk({tag, "_writes_left"}, exp_wa.size(), 0);
    $display("pass %s complete: done_count=%0d", tag, done_cnt - d0);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_src_rd"}, src_rd, 0);
    chk({tag, "_src_addr"}, src_addr, 0);
    chk({tag, "_dst_we"}, dst_we, 0);
    chk({tag, "_dst_addr"}, dst_addr, 0);
    chk({tag, "_dst_data"}, dst_data, 0);
  endtask

  initial begin
    int n, d0, k;
    vecs[0] = {8'd0,   8'd0,   8'd0,   8'd0,   8'd0};
    vecs[1] = {8'd255, 8'd255, 8'd255, 8'd254, 8'd254};
    vecs[2] = {8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
    vecs[3] = {8'd1,   8'd2,   8'd3,   8'd5,   8'd2};
    vecs[4] = {8'd100, 8'd101, 8'd102, 8'd103, 8'd101};

    rst = 1'b1; start = 1'b0; dst_ready = 1'b1; b_start = 1'b0; b_ready = 1'b1;
    load_mem();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_outputs_zero("reset");
    chk("reset_wide_busy", b_busy, 0);
    chk("reset_wide_src_rd", b_src_rd, 0);

    // Basic pass with i*4 source image.
    d0 = done_cnt;
    push_pass(base_wd[0]);
    pulse_start();
    wait_done(100, n);
    chk("basic_done_latency", n, 29);
    check_pass_end("basic", d0);

    // Table: patch block 0 with each pattern.
    for (int v = 0; v < 5; v++) begin
      load_mem();
      mem[0] = vecs[v].p0; mem[1] = vecs[v].p1; mem[4] = vecs[v].p2; mem[5] = vecs[v].p3;
      d0 = done_cnt;
      push_pass(int'(vecs[v].avg));
      pulse_start();
      wait_done(100, n);
      chk("vec_done_latency", n, 29);
      check_pass_end($sformatf("vec%0d", v), d0);
    end
    load_mem();

    // Backpressure on the first write.
    d0 = done_cnt;
    push_pass(base_wd[0]);
    dst_ready = 1'b0;
    pulse_start();
    k = 0;
    while (!dst_we && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("bp_reach_write", dst_we, 1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_dst_we", dst_we, 1);
      chk("bp_dst_addr", dst_addr, 0);
      chk("bp_dst_data", dst_data, 10);
      chk("bp_no_src_rd", src_rd, 0);
    end
    @(posedge clk); #1 dst_ready = 1'b1;
    wait_done(100, n);
    check_pass_end("backpressure", d0);

    // Reset during ISSUE of the third output pixel.
    d0 = done_cnt;
    push_pass(base_wd[0]);
    pulse_start();
    repeat (15) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
    @(negedge clk);
    check_outputs_zero("midreset");
    repeat (40) @(negedge clk);
    chk("midreset_no_done", done_cnt - d0, 0);
    chk("midreset_idle", busy, 0);
    d0 = done_cnt;
    push_pass(base_wd[0]);
    pulse_start();
    wait_done(100, n);
    chk("restart_done_latency", n, 29);
    check_pass_end("restart", d0);

    // Start pulses during ISSUE and during FIN are ignored.
    d0 = done_cnt;
    push_pass(base_wd[0]);
    pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (26) @(posedge clk);
    #1 start = 1'b1;
    @(negedge clk);
    chk("fin_done_high", done, 1);
    chk("fin_busy_low", busy, 0);
    @(posedge clk); #1 start = 1'b0;
    repeat (20) @(negedge clk);
    chk("ignored_start_busy", busy, 0);
    check_pass_end("ignored_start", d0);

    // Wide frame: row wrap at 320 and final addresses.
    @(posedge clk); #1 b_start = 1'b1;
    @(posedge clk); #1 b_start = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!b_done && n < 3000);
    chk("wide_done_latency", n, 2241);
    chk("wide_busy_in_done", b_busy, 0);
    chk("wide_write_count", b_wr_cnt, 320);
    chk("wide_last_dst_addr", b_last_wa, 319);
    chk("wide_last_dst_data", b_last_wd, 222);
    chk("wide_rd0", b_rd_hist[0], 958);
    chk("wide_rd1", b_rd_hist[1], 959);
    chk("wide_rd2", b_rd_hist[2], 1278);
    chk("wide_rd3", b_rd_hist[3], 1279);
    $display("pass wide complete: writes=%0d last_addr=%0d", b_wr_cnt, b_last_wa);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/avg_downscale_ctrl.md
Name: avg_downscale_ctrl

Overview:
- Sequences one 2x2 block-average downscale pass over a source frame buffer into a destination frame buffer.
- For each output pixel it issues four source reads and accumulates the returned pixels into a 10-bit sum. It then writes sum>>2 to the destination with a ready handshake.
- Sits between the zoom-mode control logic and the two on-chip frame RAMs. It replaces free-running address counting with a fully sequenced read/accumulate/write schedule.

Parameters:
- SRC_W, 320, source frame width in pixels; must be even.
- SRC_H, 240, source frame height in pixels; must be even.
- RD_LAT, 2, fixed source RAM read latency in cycles (1..4).
- ADDR_W, 17, width of the source and destination address buses.
- PIX_W, 8, pixel width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  begin a pass; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until the pass completes
- done  out  1  one-cycle pulse at the end of the pass
- src_rd  out  1  source read strobe
- src_addr  out  ADDR_W  source read address
- src_data  in  PIX_W  read data, valid exactly RD_LAT cycles after the src_rd cycle
- dst_we  out  1  destination write request
- dst_ready  in  1  destination accepts the write when dst_we && dst_ready
- dst_addr  out  ADDR_W  destination address
- dst_data  out  PIX_W  averaged pixel

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. On reset:
  - all outputs are 0;
  - the FSM goes to IDLE;
  - the ox, oy, row_base, sum and dst counters clear.
  - Reset mid-pass abandons the pass with no done pulse and no further writes.
- Dimensions: DST_W = SRC_W/2, DST_H = SRC_H/2. Output pixel (ox,oy) uses base = 2*oy*SRC_W + 2*ox.
  - P0 = base, P1 = base+1, P2 = base+SRC_W, P3 = base+SRC_W+1.
  - row_base tracks 2*oy*SRC_W incrementally (+2*SRC_W per output row); no multiplier.
  - dst_addr = oy*DST_W+ox, kept as an incrementing counter 0..DST_W*DST_H-1.
- FSM states: IDLE, ISSUE, DRAIN, WRITE, FIN.
- IDLE:
  - start=1 leads to ISSUE next cycle, with ox=oy=0, k=0 and sum cleared.
  - busy rises in that same next cycle.
- ISSUE (4 cycles, k=0..3):
  - src_rd=1 and src_addr=Pk; k increments each cycle.
  - After k=3, go to DRAIN.
- Accumulation: sum (PIX_W+2 bits) += src_data on each cycle where the RD_LAT-delayed copy of src_rd is 1. A shift-register valid pipe is used; no overflow is possible.
- DRAIN: held for exactly RD_LAT cycles, then WRITE. The last datum has been summed by the end of DRAIN.
- WRITE:
  - dst_we=1, dst_data = sum[PIX_W+1:2] (truncating divide by 4), dst_addr = current counter.
  - Hold all three stable while dst_ready=0.
  - On handshake: clear sum and advance ox. On ox wrap from DST_W-1 to 0, advance oy and row_base.
  - If the written pixel was the last (ox=DST_W-1, oy=DST_H-1), go to FIN; otherwise go to ISSUE with k=0.
- FIN: done=1 and busy=0 for exactly one cycle, then IDLE. start is ignored in FIN.
- start while busy, or in FIN, is ignored; no restart and no queuing.
- Throughput: 4+RD_LAT+1 cycles per output pixel with dst_ready held high (7 at default). A full default pass is 19200*7 cycles plus 1 FIN cycle.
- src_rd=0 outside ISSUE; dst_we=0 outside WRITE; src_addr and dst_data hold their last values when the strobes are low.

Test Plan:
- SRC_W=4, SRC_H=4, RD_LAT=2, dst_ready=1; source pixel i = i*4; pulse start:
  - src_addr sequence 0,1,4,5 | 2,3,6,7 | 8,9,12,13 | 10,11,14,15;
  - dst_addr 0..3 with dst_data 10,18,42,50;
  - done pulses once, 29 cycles after the start cycle; busy low in the done cycle.
- Rounding: block pixels 255,255,255,254 -> dst_data 254 (sum 1019>>2). Block all 255 -> 255, no wrap.
- Backpressure: dst_ready=0 for 5 cycles during the first WRITE -> dst_we, dst_addr=0 and dst_data stay stable; no src_rd during the stall; the pass completes with the correct data.
- Reset mid-pass: assert rst during ISSUE of pixel 2 -> next cycle all outputs 0 and no done; a fresh start restarts from src_addr 0 / dst_addr 0.
- Start while busy: extra start pulses during ISSUE and FIN -> ignored; exactly one done per accepted start.
- Default parameters, RD_LAT=2: final write at dst_addr 19199 reads src_addr 76478,76479,76798,76799; done follows.
